// File: rtl/score_tracker.sv
// score_tracker
//
// Scoring engine for the block-stacking game. Converts block-landing events
// into a saturating score with a same-colour combo multiplier, keeps the
// session high score and maintains a BCD copy of the score for the
// seven-segment driver.
//
// Ports
//   clk        : game clock, all state changes on its rising edge
//   rst        : synchronous active-high reset
//   collision  : landing level from the collision detector (may be held)
//   color      : colour of the landing block, taken on the collision edge
//   miss       : one-cycle pulse, block missed the stack (breaks the combo)
//   clear      : one-cycle new-game pulse (keeps the high score)
//   score      : current saturating score
//   high_score : highest score seen since reset
//   combo      : current combo streak, 0..COMBO_MAX
//   bcd        : BCD of the last fully converted score, MS digit on top
//   bcd_valid  : high while bcd matches score
//
// BCD converter states
//   state   | meaning
//   S_IDLE  | bcd is up to date with bcd_src; watch score for a change
//   S_LOAD  | capture score into bcd_src and the shift register
//   S_SHIFT | one add-3-then-shift step per cycle, SCORE_W steps total
module score_tracker #(
  parameter int SCORE_W   = 7,
  parameter int COMBO_MAX = 4,
  parameter int DIGITS    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           collision,
  input  logic [1:0]                     color,
  input  logic                           miss,
  input  logic                           clear,
  output logic [SCORE_W-1:0]             score,
  output logic [SCORE_W-1:0]             high_score,
  output logic [$clog2(COMBO_MAX+1)-1:0] combo,
  output logic [4*DIGITS-1:0]            bcd,
  output logic                           bcd_valid
);

  localparam int CW    = $clog2(COMBO_MAX + 1);
  // Wide enough for score + 4*COMBO_MAX without overflow.
  localparam int SUM_W = SCORE_W + CW + 3;
  localparam int SMAX  = (1 << SCORE_W) - 1;
  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int SR_W  = 4 * DIGITS + SCORE_W;

  // ---------------------------------------------------------------------
  // Scoring
  // ---------------------------------------------------------------------
  logic             coll_q;
  logic [1:0]       last_color;
  logic             hit;
  logic [CW-1:0]    combo_next;
  logic [SUM_W-1:0] base;
  logic [SUM_W-1:0] sum;
  logic [SCORE_W-1:0] score_sat;

  always_comb begin
    hit = collision & ~coll_q;
    if ((combo != '0) && (color == last_color)) begin
      combo_next = (combo == CW'(COMBO_MAX)) ? combo : combo + CW'(1);
    end else begin
      combo_next = CW'(1);
    end
    base      = SUM_W'(color) + SUM_W'(1);
    sum       = SUM_W'(score) + base * SUM_W'(combo_next);
    score_sat = (sum > SUM_W'(SMAX)) ? SCORE_W'(SMAX) : sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q     <= 1'b0;
      score      <= '0;
      combo      <= '0;
      last_color <= '0;
      high_score <= '0;
    end else begin
      // coll_q tracks even during clear so a held level never rescores.
      coll_q <= collision;
      if (score > high_score) begin
        high_score <= score;
      end
      if (clear) begin
        score      <= '0;
        combo      <= '0;
        last_color <= '0;
      end else if (hit) begin
        score      <= score_sat;
        combo      <= combo_next;
        last_color <= color;
      end else if (miss) begin
        combo <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sequential double-dabble BCD converter
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [SCORE_W-1:0]  bcd_src;
  logic [SCORE_W-1:0]  sh_bin;
  logic [4*DIGITS-1:0] sh_bcd;
  logic [4*DIGITS-1:0] dig_adj;
  logic [SR_W-1:0]     sh_next;
  logic [CNT_W-1:0]    cnt;
  logic                src_diff;
  logic                conv_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    conv_done = 1'b0;
    src_diff  = (score != bcd_src);
    case (state)
      S_IDLE: begin
        if (src_diff) begin
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        // A score change wins over finishing: a stale result is never written.
        if (src_diff) begin
          state_nx = S_LOAD;
        end else if (cnt == '0) begin
          state_nx  = S_IDLE;
          conv_done = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    dig_adj = sh_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i +: 4] >= 4'd5) begin
        dig_adj[4*i +: 4] = sh_bcd[4*i +: 4] + 4'd3;
      end
    end
    sh_next = {dig_adj, sh_bin} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_src   <= '0;
      sh_bin    <= '0;
      sh_bcd    <= '0;
      cnt       <= '0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (src_diff) begin
            bcd_valid <= 1'b0;
          end
        end
        S_LOAD: begin
          bcd_src <= score;
          sh_bin  <= score;
          sh_bcd  <= '0;
          cnt     <= CNT_W'(SCORE_W - 1);
        end
        S_SHIFT: begin
          if (!src_diff) begin
            sh_bcd <= sh_next[SR_W-1:SCORE_W];
            sh_bin <= sh_next[SCORE_W-1:0];
            cnt    <= cnt - CNT_W'(1);
            if (conv_done) begin
              bcd       <= sh_next[SR_W-1:SCORE_W];
              bcd_valid <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker with default parameters. A
// behavioural model of the scoring rules runs alongside the DUT; BCD
// expectations come from decimal arithmetic on the model score.
module tb_score_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        collision = 1'b0;
  logic [1:0]  color = 2'd0;
  logic        miss = 1'b0;
  logic        clear = 1'b0;
  logic [6:0]  score;
  logic [6:0]  high_score;
  logic [2:0]  combo;
  logic [11:0] bcd;
  logic        bcd_valid;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_score, m_combo, m_last, m_high;

  score_tracker #(.SCORE_W(7), .COMBO_MAX(4), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .collision(collision), .color(color),
    .miss(miss), .clear(clear), .score(score), .high_score(high_score),
    .combo(combo), .bcd(bcd), .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset;
    m_score = 0; m_combo = 0; m_last = 0; m_high = 0;
  endtask

  task automatic m_clear;
    m_score = 0; m_combo = 0; m_last = 0;
  endtask

  task automatic m_hit(input int c);
    if (m_combo > 0 && c == m_last) m_combo = (m_combo < 4) ? m_combo + 1 : 4;
    else m_combo = 1;
    m_last  = c;
    m_score = m_score + (c + 1) * m_combo;
    if (m_score > 127) m_score = 127;
  endtask

  task automatic m_track_high;
    if (m_score > m_high) m_high = m_score;
  endtask

  task automatic press(input int c);
    collision = 1'b1;
    color = 2'(c);
    tick;
  endtask

  task automatic release_coll;
    collision = 1'b0;
    tick;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    m_clear;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    m_reset;
    checks++; if (score !== 7'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (high_score !== 7'd0) begin errors++; $display("FAIL reset_high: got %0d want 0", high_score); end
    checks++; if (combo !== 3'd0) begin errors++; $display("FAIL reset_combo: got %0d want 0", combo); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h want 000", bcd); end
    checks++; if (bcd_valid !== 1'b1) begin errors++; $display("FAIL reset_valid: got %b want 1", bcd_valid); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_held_collision;
    int prev_high;
    prev_high = m_high;
    collision = 1'b1; color = 2'd1;
    tick;
    m_hit(1);
    checks++; if (score !== 7'(m_score)) begin errors++; $display("FAIL held_first: score %0d want %0d", score, m_score); end
    checks++; if (combo !== 3'(m_combo)) begin errors++; $display("FAIL held_combo: combo %0d want %0d", combo, m_combo); end
    checks++; if (high_score !== 7'(prev_high)) begin errors++; $display("FAIL held_high_lag: high %0d want %0d", high_score, prev_high); end
    tick;
    m_track_high;
    checks++; if (high_score !== 7'(m_high)) begin errors++; $display("FAIL held_high: high %0d want %0d", high_score, m_high); end
    tick;
    checks++; if (score !== 7'd2) begin errors++; $display("FAIL held_no_rescore: score %0d want 2", score); end
    release_coll;
  endtask

  task automatic test_combo_build;
    int cols[4] = '{2, 2, 2, 0};
    int exp_s[4] = '{3, 9, 18, 19};
    do_clear;
    checks++; if (score !== 7'd0 || combo !== 3'd0) begin errors++; $display("FAIL build_clear: score %0d combo %0d want 0 0", score, combo); end
    for (int i = 0; i < 4; i++) begin
      press(cols[i]);
      m_hit(cols[i]);
      checks++; if (score !== 7'(m_score) || score !== 7'(exp_s[i])) begin errors++; $display("FAIL build_score[%0d]: score %0d want %0d", i, score, exp_s[i]); end
      checks++; if (combo !== 3'(m_combo)) begin errors++; $display("FAIL build_combo[%0d]: combo %0d want %0d", i, combo, m_combo); end
      release_coll;
      m_track_high;
      checks++; if (high_score !== 7'(m_high)) begin errors++; $display("FAIL build_high[%0d]: high %0d want %0d", i, high_score, m_high); end
    end
  endtask

  task automatic test_combo_cap_sat;
    do_clear;
    for (int i = 0; i < 12; i++) begin
      press(3);
      m_hit(3);
      checks++; if (score !== 7'(m_score)) begin errors++; $display("FAIL sat_score[%0d]: score %0d want %0d", i, score, m_score); end
      checks++; if (combo !== 3'(m_combo)) begin errors++; $display("FAIL sat_combo[%0d]: combo %0d want %0d", i, combo, m_combo); end
      release_coll;
      m_track_high;
    end
    checks++; if (score !== 7'd127) begin errors++; $display("FAIL sat_clamp: score %0d want 127", score); end
    checks++; if (combo !== 3'd4) begin errors++; $display("FAIL combo_cap: combo %0d want 4", combo); end
    checks++; if (high_score !== 7'd127) begin errors++; $display("FAIL sat_high: high %0d want 127", high_score); end
  endtask

  task automatic test_miss_clear;
    do_clear;
    for (int i = 0; i < 3; i++) begin
      press(2); m_hit(2); release_coll; m_track_high;
    end
    checks++; if (score !== 7'(m_score) || combo !== 3'(m_combo)) begin errors++; $display("FAIL mc_setup: score %0d combo %0d want %0d %0d", score, combo, m_score, m_combo); end
    miss = 1'b1; tick; miss = 1'b0;
    m_combo = 0;
    checks++; if (combo !== 3'd0) begin errors++; $display("FAIL miss_combo: combo %0d want 0", combo); end
    checks++; if (score !== 7'(m_score)) begin errors++; $display("FAIL miss_score: score %0d want %0d", score, m_score); end
    press(2); m_hit(2);
    checks++; if (combo !== 3'd1 || score !== 7'(m_score)) begin errors++; $display("FAIL after_miss: combo %0d score %0d want 1 %0d", combo, score, m_score); end
    release_coll; m_track_high;
    // clear beats a coincident hit
    clear = 1'b1; press(1); clear = 1'b0;
    m_clear;
    checks++; if (score !== 7'd0 || combo !== 3'd0) begin errors++; $display("FAIL clear_hit: score %0d combo %0d want 0 0", score, combo); end
    checks++; if (high_score !== 7'(m_high)) begin errors++; $display("FAIL clear_keeps_high: high %0d want %0d", high_score, m_high); end
    release_coll;
    // hit beats a coincident miss
    miss = 1'b1; press(1); miss = 1'b0;
    m_hit(1);
    checks++; if (combo !== 3'(m_combo) || score !== 7'(m_score)) begin errors++; $display("FAIL hit_miss: combo %0d score %0d want %0d %0d", combo, score, m_combo, m_score); end
    release_coll; m_track_high;
    // collision held across clear does not rescore
    press(0); m_hit(0);
    checks++; if (score !== 7'(m_score)) begin errors++; $display("FAIL held_pre_clear: score %0d want %0d", score, m_score); end
    clear = 1'b1; tick; clear = 1'b0;
    m_clear;
    tick;
    checks++; if (score !== 7'd0 || combo !== 3'd0) begin errors++; $display("FAIL held_across_clear: score %0d combo %0d want 0 0", score, combo); end
    release_coll;
  endtask

  task automatic test_bcd;
    logic [11:0] old;
    int n;
    do_clear;
    repeat (12) tick;
    checks++; if (bcd_valid !== 1'b1 || bcd !== to_bcd(m_score)) begin errors++; $display("FAIL bcd_zero: bcd %h valid %b want %h 1", bcd, bcd_valid, to_bcd(m_score)); end
    for (int i = 0; i < 2; i++) begin
      press(2); m_hit(2); release_coll; m_track_high;
      repeat (12) tick;
      checks++; if (bcd_valid !== 1'b1 || bcd !== to_bcd(m_score)) begin errors++; $display("FAIL bcd_settle[%0d]: bcd %h valid %b want %h 1", i, bcd, bcd_valid, to_bcd(m_score)); end
    end
    old = to_bcd(m_score);
    press(2); m_hit(2);
    checks++; if (bcd_valid !== 1'b1) begin errors++; $display("FAIL bcd_valid_lag: valid %b want 1", bcd_valid); end
    collision = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick;
      if (k < 9) begin
        checks++; if (bcd_valid !== 1'b0 || bcd !== old) begin errors++; $display("FAIL bcd_busy[%0d]: bcd %h valid %b want %h 0", k, bcd, bcd_valid, old); end
      end else begin
        checks++; if (bcd_valid !== 1'b1 || bcd !== to_bcd(m_score) || bcd !== 12'h018) begin errors++; $display("FAIL bcd_done: bcd %h valid %b want 018 1", bcd, bcd_valid); end
      end
    end
    m_track_high;
    // restart mid-SHIFT
    old = bcd;
    press(2); m_hit(2);
    collision = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick;
      checks++; if (bcd_valid !== 1'b0 || bcd !== old) begin errors++; $display("FAIL bcd_conv1[%0d]: bcd %h valid %b want %h 0", k, bcd, bcd_valid, old); end
    end
    press(2); m_hit(2);
    collision = 1'b0;
    checks++; if (bcd_valid !== 1'b0 || bcd !== old) begin errors++; $display("FAIL bcd_restart: bcd %h valid %b want %h 0", bcd, bcd_valid, old); end
    n = 0;
    while (bcd_valid !== 1'b1 && n < 30) begin
      tick;
      n++;
      if (bcd_valid !== 1'b1) begin
        checks++; if (bcd !== old) begin errors++; $display("FAIL bcd_partial[%0d]: bcd %h want %h", n, bcd, old); end
      end
    end
    checks++; if (n != 9) begin errors++; $display("FAIL bcd_restart_time: cycles %0d want 9", n); end
    checks++; if (bcd !== to_bcd(m_score) || score !== 7'(m_score)) begin errors++; $display("FAIL bcd_final: bcd %h score %0d want %h %0d", bcd, score, to_bcd(m_score), m_score); end
    m_track_high;
  endtask

  task automatic test_reset_mid;
    int seq[11] = '{3, 3, 3, 3, 0, 0, 0, 0, 0, 1, 0};
    do_clear;
    for (int i = 0; i < 10; i++) begin
      press(seq[i]); m_hit(seq[i]); release_coll; m_track_high;
    end
    press(seq[10]); m_hit(seq[10]);
    checks++; if (score !== 7'd57 || score !== 7'(m_score)) begin errors++; $display("FAIL rm_setup: score %0d want 57", score); end
    collision = 1'b0;
    repeat (4) tick;
    checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL rm_busy: valid %b want 0", bcd_valid); end
    rst = 1'b1;
    tick;
    m_reset;
    checks++; if (score !== 7'd0 || high_score !== 7'd0 || combo !== 3'd0) begin errors++; $display("FAIL rm_regs: score %0d high %0d combo %0d want 0 0 0", score, high_score, combo); end
    checks++; if (bcd !== 12'h000 || bcd_valid !== 1'b1) begin errors++; $display("FAIL rm_bcd: bcd %h valid %b want 000 1", bcd, bcd_valid); end
    rst = 1'b0;
    repeat (12) tick;
    checks++; if (bcd !== 12'h000 || bcd_valid !== 1'b1 || score !== 7'd0) begin errors++; $display("FAIL rm_quiet: bcd %h valid %b score %0d want 000 1 0", bcd, bcd_valid, score); end
  endtask

  task automatic test_random;
    int op, c;
    logic mis, clr;
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        c   = $urandom_range(0, 3);
        mis = ($urandom_range(0, 3) == 0);
        clr = ($urandom_range(0, 9) == 0);
        miss = mis; clear = clr;
        press(c);
        miss = 1'b0; clear = 1'b0;
        if (clr) m_clear; else m_hit(c);
        checks++; if (score !== 7'(m_score) || combo !== 3'(m_combo)) begin errors++; $display("FAIL rnd_hit[%0d]: score %0d combo %0d want %0d %0d", it, score, combo, m_score, m_combo); end
        release_coll;
        m_track_high;
        checks++; if (high_score !== 7'(m_high)) begin errors++; $display("FAIL rnd_high[%0d]: high %0d want %0d", it, high_score, m_high); end
      end else if (op <= 7) begin
        miss = 1'b1; tick; miss = 1'b0;
        m_combo = 0;
        checks++; if (score !== 7'(m_score) || combo !== 3'd0) begin errors++; $display("FAIL rnd_miss[%0d]: score %0d combo %0d want %0d 0", it, score, combo, m_score); end
      end else if (op == 8) begin
        do_clear;
        checks++; if (score !== 7'd0 || combo !== 3'd0 || high_score !== 7'(m_high)) begin errors++; $display("FAIL rnd_clear[%0d]: score %0d combo %0d high %0d want 0 0 %0d", it, score, combo, high_score, m_high); end
      end else begin
        repeat (11) tick;
        checks++; if (bcd_valid !== 1'b1 || bcd !== to_bcd(m_score)) begin errors++; $display("FAIL rnd_bcd[%0d]: bcd %h valid %b want %h 1", it, bcd, bcd_valid, to_bcd(m_score)); end
      end
    end
    repeat (12) tick;
    checks++; if (bcd_valid !== 1'b1 || bcd !== to_bcd(m_score)) begin errors++; $display("FAIL rnd_end_bcd: bcd %h valid %b want %h 1", bcd, bcd_valid, to_bcd(m_score)); end
    checks++; if (high_score !== 7'(m_high)) begin errors++; $display("FAIL rnd_end_high: high %0d want %0d", high_score, m_high); end
  endtask

  initial begin
    m_reset;
    test_reset;
    test_held_collision;
    test_combo_build;
    test_combo_cap_sat;
    test_miss_clear;
    test_bcd;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_tracker.md
# score_tracker

Parametrised scoring engine for the block-stacking game. It converts block-landing events (`collision` plus the landed block's `color`) into a saturating score with a same-colour combo multiplier, keeps a session high score, and produces a BCD copy of the score for the seven-segment display driver. It sits between the collision detector and the display/VGA text logic, in the game clock domain.

## Interface

- `SCORE_W`, 7: score and high-score width in bits; the score saturates at 2^SCORE_W-1.
- `COMBO_MAX`, 4: combo multiplier cap, at least 1.
- `DIGITS`, 3: number of BCD digits; must satisfy 10^DIGITS > 2^SCORE_W-1.

- `clk` in 1: game clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `collision` in 1: level from the collision detector; it may stay high for several cycles per landing.
- `color` in 2: colour of the landing block, sampled on the rising edge of `collision`.
- `miss` in 1: single-cycle pulse when a block misses the stack; breaks the combo.
- `clear` in 1: single-cycle new-game pulse; zeroes the score and combo state, keeps the high score.
- `score` out SCORE_W: current score.
- `high_score` out SCORE_W: maximum score reached since reset.
- `combo` out clog2(COMBO_MAX+1): current combo streak, 0 to COMBO_MAX.
- `bcd` out 4*DIGITS: BCD of the last fully converted score; most significant digit is in the top nibble.
- `bcd_valid` out 1: high when `bcd` matches `score`.

## Operation

- **Edge detect:** register `collision` into `coll_q`. An event is `hit = collision & ~coll_q`, so a held level scores exactly once.
- **Points:** base value is `color + 1` (1 to 4).
- **Combo:** keep `last_color`.
  - On a hit with `combo > 0` and `color == last_color`: `combo <= min(combo+1, COMBO_MAX)`.
  - On any other hit: `combo <= 1`.
  - `last_color <= color` on every hit.
- **Add:** `score <= sat(score + base*combo_next)`, computed at least SCORE_W+1 bits wide. Results above 2^SCORE_W-1 clamp to 2^SCORE_W-1. Once at max, the score holds and combo still updates.
- **Miss:** `combo <= 0`; score unchanged.
- **Priority** when events coincide in one cycle: `rst` > `clear` > hit > `miss`. A `miss` coinciding with a hit is ignored.
- **High score:** `high_score <= score` whenever `score > high_score`.
- **BCD converter FSM** (sequential double-dabble):
  - States: IDLE, LOAD, SHIFT.
  - IDLE: if `score != bcd_src`, go to LOAD and drop `bcd_valid`.
  - LOAD: `bcd_src <= score`, clear the shift register.
  - SHIFT: SCORE_W iterations of add-3-then-shift, then write `bcd`, raise `bcd_valid`, return to IDLE.
  - If `score` changes during SHIFT, abort and go to LOAD with the new value. `bcd` keeps its previous value until a conversion completes.
- **Reset values:** `score` = 0, `high_score` = 0, `combo` = 0, `last_color` = 0, `coll_q` = 0, `bcd` = 0, `bcd_valid` = 1, FSM in IDLE, `bcd_src` = 0.
- **Clear:** `score` = 0, `combo` = 0, `last_color` = 0. `coll_q` keeps tracking, so a collision held across `clear` does not rescore. The converter then converts 0.

## Timing

- Hit to `score`/`combo` update: 1 cycle. The new value is visible after the first rising edge at which `collision` = 1 and `coll_q` = 0.
- `score` to `high_score`: 1 further cycle.
- `score` change to `bcd_valid` high, with no further changes: SCORE_W+2 cycles (1 IDLE detect, 1 LOAD, SCORE_W SHIFT). `bcd_valid` falls the cycle after the detect.
- Back-to-back hits need `collision` low for at least 1 cycle between them; the minimum hit spacing is 2 cycles.
- A `rst` at any point, including mid-conversion, returns all state to its reset values on that edge.

## Test plan

All scenarios use the default parameters.

- **Held collision:** release `rst`; hold `collision` = 1 for 3 cycles with `color` = 01 → `score` = 2 after the first edge and stays 2; `combo` = 1; `high_score` = 2 one cycle later.
- **Combo build:** three separate hits with `color` = 10 → `score` 3, then 9, then 18; `combo` 1, 2, 3. A fourth hit with `color` = 00 → `score` 19, `combo` = 1.
- **Combo cap and saturation:** repeated hits with `color` = 11 → adds 4, 8, 12, 16, 16, …; `combo` holds at 4; `score` clamps at 127 (never wraps) and stays 127 on further hits.
- **Miss, clear and priority:** after `score` = 18 and `combo` = 3, pulse `miss` → `combo` = 0, `score` = 18. Next hit → `combo` = 1. Pulse `clear` together with a hit → `score` = 0, `combo` = 0, `high_score` keeps its prior maximum.
- **BCD:** `score` goes to 18 → `bcd_valid` falls, then rises 9 cycles after the change with `bcd` = 0x018. A second hit during SHIFT → conversion restarts; the final `bcd` equals the final score; `bcd` = 0x018 is never replaced by a partial value.
- **Reset mid-operation:** assert `rst` during SHIFT with `score` = 57 → on the next edge all outputs are at their reset values, `bcd_valid` = 1 and `bcd` = 0x000.
